// File: rtl/rt_pkg.sv
// Shared types and constants for the racetrack word access/shift controller.
package rt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        ACCESS,
        RESP
    } rt_ctrl_state_e;

    localparam logic RT_DIR_FWD = 1'b0;
    localparam logic RT_DIR_BWD = 1'b1;

    // Accept-to-response latency in cycles for an in-range access needing k shifts.
    function automatic int unsigned lat(input int unsigned k);
        return 2 * k + 3;
    endfunction

endpackage

// File: rtl/rt_track_ctrl_if.sv
// Request/response handshake between a requester and the racetrack controller.
interface rt_track_ctrl_if #(
    parameter int N_WORDS = 32,
    parameter int WORD_W  = 32
);
    localparam int AW = $clog2(N_WORDS);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [WORD_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/rt_shift_seq.sv
// Shift pulse generator: holds the remaining step count and direction, tracks the track offset.
module rt_shift_seq
    import rt_pkg::*;
#(
    parameter int  N_WORDS = 32,
    localparam int AW      = $clog2(N_WORDS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [AW-1:0] k_in,
    input  logic          dir_in,
    input  logic          step,
    output logic          current_m,
    output logic [AW-1:0] offset,
    output logic          done
);

    logic [AW-1:0] k_q;
    logic          dir_q;

    // step is the decoded "next state is SHIFT_HI", so the pulse and offset move land together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q       <= '0;
            dir_q     <= RT_DIR_FWD;
            current_m <= 1'b0;
            offset    <= '0;
        end else begin
            current_m <= step;
            if (load) begin
                k_q   <= k_in;
                dir_q <= dir_in;
            end else if (step) begin
                k_q    <= k_q - 1'b1;
                offset <= (dir_q == RT_DIR_BWD) ? offset + 1'b1 : offset - 1'b1;
            end
        end
    end

    assign done = (k_q == '0);

endmodule

// File: rtl/rt_track_ctrl.sv
// Racetrack word controller: turns word requests into shift pulses, write strobes and read samples.
module rt_track_ctrl
    import rt_pkg::*;
#(
    parameter int  N_WORDS = 32,
    parameter int  WORD_W  = 32,
    localparam int AW      = $clog2(N_WORDS)
) (
    input  logic              clk,
    input  logic              rstn,
    rt_track_ctrl_if.slave    bus,
    output logic              current_m,
    output logic              current_s,
    output logic [WORD_W-1:0] write_enable,
    output logic [WORD_W-1:0] write_input,
    input  logic [WORD_W-1:0] port_bit_i,
    output logic [AW-1:0]     offset_o
);

    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(N_WORDS);

    rt_ctrl_state_e    state, state_nxt;
    logic              ready, accept, step, shift_done, addr_err, dir_nxt;
    logic [AW-1:0]     k_nxt;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [WORD_W-1:0] rsp_rdata_q;

    assign ready    = (state == IDLE) || (state == RESP);
    assign accept   = bus.req_valid && ready;
    assign dir_nxt  = (bus.req_addr > offset_o) ? RT_DIR_BWD : RT_DIR_FWD;
    assign k_nxt    = (dir_nxt == RT_DIR_BWD) ? bus.req_addr - offset_o : offset_o - bus.req_addr;
    assign addr_err = ({1'b0, addr_q} >= ADDR_LIMIT);
    assign step     = (state_nxt == SHIFT_HI);

    rt_shift_seq #(.N_WORDS(N_WORDS)) u_shift_seq (
        .clk       (clk),
        .rstn      (rstn),
        .load      (accept),
        .k_in      (k_nxt),
        .dir_in    (dir_nxt),
        .step      (step),
        .current_m (current_m),
        .offset    (offset_o),
        .done      (shift_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // RESP doubles as an idle cycle so a waiting request is taken without a bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = SETUP;
            SETUP:    if (addr_err)         state_nxt = RESP;
                      else if (!shift_done) state_nxt = SHIFT_HI;
                      else                  state_nxt = ACCESS;
            SHIFT_HI: state_nxt = SHIFT_LO;
            SHIFT_LO: state_nxt = shift_done ? ACCESS : SHIFT_HI;
            ACCESS:   state_nxt = RESP;
            RESP:     state_nxt = accept ? SETUP : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Cell-facing and response outputs decode the next state so they come straight from flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            current_s    <= RT_DIR_FWD;
            write_enable <= '0;
            write_input  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            rsp_valid_q  <= (state_nxt == RESP);
            rsp_err_q    <= (state == SETUP) && addr_err;
            write_enable <= (state_nxt == ACCESS && we_q) ? '1 : '0;
            if (accept)
                current_s <= dir_nxt;
            if (state_nxt == ACCESS && we_q)
                write_input <= wdata_q;
            if (state_nxt == RESP)
                rsp_rdata_q <= (state == ACCESS && !we_q) ? port_bit_i : '0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
